// File: rtl/bus_txn_ctrl_if.sv
// Bus transaction controller signal bundle: arbiter grant/request side and slave side.
// The master modport is the controller's view; slave is the view of whatever surrounds it.
interface bus_txn_ctrl_if #(
    parameter int BURST_W = 4
);
    logic [1:0]         bus_grant;
    logic [1:0]         slave_sel;
    logic               m_mode;
    logic [BURST_W-1:0] m_burst;
    logic [2:0]         s_ready;
    logic [2:0]         s_rvalid;
    logic [2:0]         s_en;
    logic               addr_phase;
    logic               data_phase;
    logic [BURST_W-1:0] beat_cnt;
    logic               trans_done;
    logic               trans_err;
    logic               busy;

    modport master (
        input  bus_grant, slave_sel, m_mode, m_burst, s_ready, s_rvalid,
        output s_en, addr_phase, data_phase, beat_cnt, trans_done, trans_err, busy
    );

    modport slave (
        output bus_grant, slave_sel, m_mode, m_burst, s_ready, s_rvalid,
        input  s_en, addr_phase, data_phase, beat_cnt, trans_done, trans_err, busy
    );
endinterface

// File: rtl/bus_txn_ctrl.sv
// Sequences one granted bus transaction: address phase, ack wait, data beats, done pulse.
// Define TXN_TIMEOUT_EN to abort after TIMEOUT_CYC consecutive stall cycles.
module bus_txn_ctrl #(
    parameter int BURST_W     = 4,
    parameter int ADDR_CYC    = 2,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic           clk,
    input  logic           rst,
    bus_txn_ctrl_if.master bus
);
    localparam int ACW = (ADDR_CYC > 1) ? $clog2(ADDR_CYC) : 1;
    localparam logic [ACW-1:0] ACNT_LAST = ACW'(ADDR_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT_ACK,
        S_DATA,
        S_DONE,
        S_RELEASE
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic               mode_q, mode_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic               err_q, err_d;
    logic [ACW-1:0]     acnt_q, acnt_d;

    logic       grant_ok;
    logic [2:0] sel_oh;
    logic       ack;
    logic       beat_hs;
    logic       timeout;

    assign grant_ok = (bus.bus_grant == 2'b01) || (bus.bus_grant == 2'b10);
    // A latched select of 3 shifts out to 000, so no slave is ever enabled for it
    assign sel_oh   = 3'b001 << sel_q;
    assign ack      = |(bus.s_ready & sel_oh);
    assign beat_hs  = mode_q ? ack : |(bus.s_rvalid & sel_oh);

`ifdef TXN_TIMEOUT_EN
    localparam int SCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SCW-1:0] STALL_LAST = SCW'(TIMEOUT_CYC - 1);
    localparam logic [SCW-1:0] STALL_SAT  = SCW'(TIMEOUT_CYC);

    logic [SCW-1:0] stall_q, stall_d;
    logic           stalling;

    assign stalling = ((state_q == S_WAIT_ACK) && !ack) ||
                      ((state_q == S_DATA) && !beat_hs);
    assign timeout  = stalling && (stall_q == STALL_LAST);

    always_comb begin
        stall_d = stall_q;
        if ((state_d == S_WAIT_ACK) && (state_q != S_WAIT_ACK)) begin
            stall_d = '0;
        end else if ((state_q == S_WAIT_ACK) || (state_q == S_DATA)) begin
            if (!stalling) begin
                stall_d = '0;
            end else if (stall_q != STALL_SAT) begin
                stall_d = stall_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        mode_d  = mode_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        err_d   = err_q;
        acnt_d  = acnt_q;
        case (state_q)
            S_IDLE: begin
                err_d  = 1'b0;
                acnt_d = '0;
                if (grant_ok) begin
                    sel_d   = bus.slave_sel;
                    mode_d  = bus.m_mode;
                    burst_d = bus.m_burst;
                    if (bus.slave_sel == 2'd3) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (!grant_ok) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else if (acnt_q == ACNT_LAST) begin
                    state_d = S_WAIT_ACK;
                end else begin
                    acnt_d = acnt_q + 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (!grant_ok || (!ack && timeout)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else if (ack) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!grant_ok || (!beat_hs && timeout)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else if (beat_hs) begin
                    if (beat_q == burst_q) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!grant_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Beat index is only meaningful inside the data phase; entering it starts at 0
        if (state_d != S_DATA) begin
            beat_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            mode_q  <= 1'b0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            acnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            acnt_q  <= acnt_d;
        end
    end

    assign bus.s_en       = ((state_q == S_ADDR) || (state_q == S_WAIT_ACK) ||
                             (state_q == S_DATA)) ? sel_oh : 3'b000;
    assign bus.addr_phase = (state_q == S_ADDR);
    assign bus.data_phase = (state_q == S_DATA);
    assign bus.beat_cnt   = beat_q;
    assign bus.trans_done = (state_q == S_DONE);
    assign bus.trans_err  = (state_q == S_DONE) && err_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_bus_txn_ctrl.sv
// Directed bench for bus_txn_ctrl; completions are checked against a scoreboard of
// expected error flag and completion cycle pushed when each grant is driven.
module tb_bus_txn_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   t0 = 0;

    typedef struct {
        logic err;
        int   cyc;
    } exp_t;

    exp_t sb_q[$];

    bus_txn_ctrl_if #(.BURST_W(4)) bif ();

    bus_txn_ctrl #(
        .BURST_W(4),
        .ADDR_CYC(2),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input logic err, input int dcyc);
        exp_t e;
        e.err = err;
        e.cyc = dcyc;
        sb_q.push_back(e);
    endtask

    task automatic start(input logic [1:0] g, input logic [1:0] sel, input logic mode,
                         input logic [3:0] burst);
        bif.bus_grant = g;
        bif.slave_sel = sel;
        bif.m_mode    = mode;
        bif.m_burst   = burst;
        t0            = cyc;
    endtask

    always @(negedge clk) begin
        if (rst && bif.trans_done) begin
            exp_t e;
            chk("sb_has_entry", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("done_err", bif.trans_err, e.err);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        bif.bus_grant = 2'b00;
        bif.slave_sel = 2'd0;
        bif.m_mode    = 1'b0;
        bif.m_burst   = 4'd0;
        bif.s_ready   = 3'b000;
        bif.s_rvalid  = 3'b000;

        tick();
        tick();
        chk("rst_busy", bif.busy, 0);
        chk("rst_s_en", bif.s_en, 0);
        chk("rst_done", bif.trans_done, 0);
        chk("rst_addr_phase", bif.addr_phase, 0);
        chk("rst_beat", bif.beat_cnt, 0);
        rst = 1'b1;
        tick();

        // write burst of 4 to slave 2, no stalls
        bif.s_ready = 3'b111;
        start(2'b01, 2'd2, 1'b1, 4'd3);
        expect_done(1'b0, t0 + 8);
        tick();
        chk("t2_addr0", bif.addr_phase, 1);
        chk("t2_s_en", bif.s_en, 3'b100);
        chk("t2_busy", bif.busy, 1);
        bif.slave_sel = 2'd0;
        tick();
        chk("t2_addr1", bif.addr_phase, 1);
        chk("t2_sel_held", bif.s_en, 3'b100);
        tick();
        chk("t2_wait_addr", bif.addr_phase, 0);
        chk("t2_wait_data", bif.data_phase, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_data_phase", bif.data_phase, 1);
            chk("t2_beat", bif.beat_cnt, i);
        end
        tick();
        chk("t2_done", bif.trans_done, 1);
        chk("t2_done_s_en", bif.s_en, 0);
        chk("t2_done_dphase", bif.data_phase, 0);
        bif.bus_grant = 2'b00;
        tick();
        chk("t2_release_busy", bif.busy, 1);
        tick();
        chk("t2_idle", bif.busy, 0);

        // read burst of 2 from slave 0 with rvalid every other cycle, grant held
        bif.s_rvalid = 3'b000;
        start(2'b10, 2'd0, 1'b0, 4'd1);
        expect_done(1'b0, t0 + 8);
        tick();
        tick();
        tick();
        tick();
        chk("t3_beat0", bif.beat_cnt, 0);
        bif.s_rvalid = 3'b110;
        tick();
        chk("t3_stall_beat", bif.beat_cnt, 0);
        chk("t3_stall_dphase", bif.data_phase, 1);
        bif.s_rvalid = 3'b001;
        tick();
        chk("t3_beat1", bif.beat_cnt, 1);
        bif.s_rvalid = 3'b000;
        tick();
        chk("t3_beat1_hold", bif.beat_cnt, 1);
        bif.s_rvalid = 3'b001;
        tick();
        chk("t3_done", bif.trans_done, 1);
        chk("t3_err", bif.trans_err, 0);
        bif.s_rvalid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_release_busy", bif.busy, 1);
        end
        bif.bus_grant = 2'b00;
        tick();
        chk("t3_idle", bif.busy, 0);

        // slave 1 never acknowledges
        bif.s_ready = 3'b101;
        start(2'b01, 2'd1, 1'b1, 4'd0);
`ifdef TXN_TIMEOUT_EN
        expect_done(1'b1, t0 + 11);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("t4_busy", bif.busy, 1);
            chk("t4_no_done", bif.trans_done, 0);
        end
        tick();
        chk("t4_done", bif.trans_done, 1);
        chk("t4_err", bif.trans_err, 1);
        bif.bus_grant = 2'b00;
        tick();
        tick();
        chk("t4_idle", bif.busy, 0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i % 10 == 9) begin
                chk("t4_busy", bif.busy, 1);
                chk("t4_s_en", bif.s_en, 3'b010);
            end
        end
        bif.bus_grant = 2'b00;
        expect_done(1'b1, cyc + 1);
        tick();
        chk("t4_abort_done", bif.trans_done, 1);
        tick();
        tick();
        chk("t4_idle", bif.busy, 0);
`endif

        // invalid slave select
        bif.s_ready = 3'b111;
        start(2'b01, 2'd3, 1'b1, 4'd0);
        expect_done(1'b1, t0 + 1);
        tick();
        chk("t5_done", bif.trans_done, 1);
        chk("t5_s_en", bif.s_en, 0);
        chk("t5_addr", bif.addr_phase, 0);
        bif.bus_grant = 2'b00;
        tick();
        chk("t5_addr_rel", bif.addr_phase, 0);
        chk("t5_release_busy", bif.busy, 1);
        tick();
        chk("t5_idle", bif.busy, 0);

        // grant withdrawn during data phase at beat 1
        start(2'b01, 2'd0, 1'b1, 4'd3);
        expect_done(1'b1, t0 + 6);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_beat1", bif.beat_cnt, 1);
        bif.bus_grant = 2'b00;
        tick();
        chk("t6_done", bif.trans_done, 1);
        chk("t6_err", bif.trans_err, 1);
        tick();
        chk("t6_release_busy", bif.busy, 1);
        tick();
        chk("t6_idle", bif.busy, 0);

        // maximum burst ends at all-ones beat without wrapping
        start(2'b01, 2'd1, 1'b1, 4'd15);
        expect_done(1'b0, t0 + 20);
        tick();
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t7_beat", bif.beat_cnt, i);
        end
        tick();
        chk("t7_done", bif.trans_done, 1);
        bif.bus_grant = 2'b00;
        tick();
        tick();
        chk("t7_idle", bif.busy, 0);

        // asynchronous reset in the middle of a data phase
        start(2'b01, 2'd1, 1'b1, 4'd3);
        for (int i = 0; i < 5; i++) tick();
        chk("t1_pre_dphase", bif.data_phase, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("t1_busy", bif.busy, 0);
        chk("t1_s_en", bif.s_en, 0);
        chk("t1_dphase", bif.data_phase, 0);
        chk("t1_beat", bif.beat_cnt, 0);
        chk("t1_done", bif.trans_done, 0);
        bif.bus_grant = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("t1_idle", bif.busy, 0);
        chk("t1_no_done", bif.trans_done, 0);

        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
